// File: rtl/y86_pkg.sv
// Shared Y86-64 decode definitions: instruction codes, register indices and
// the datapath width used by the decode/register-read slice.
package y86_pkg;

    localparam int DATA_W = 64;
    localparam int NREG   = 15;

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    typedef enum logic [3:0] {
        I_HALT  = 4'h0,
        I_NOP   = 4'h1,
        I_RRMOV = 4'h2,
        I_IRMOV = 4'h3,
        I_RMMOV = 4'h4,
        I_MRMOV = 4'h5,
        I_OPQ   = 4'h6,
        I_JXX   = 4'h7,
        I_CALL  = 4'h8,
        I_RET   = 4'h9,
        I_PUSH  = 4'hA,
        I_POP   = 4'hB
    } icode_e;

endpackage

// File: rtl/regfile_2r2w.sv
// Y86-64 register file: 15 entries, two write ports (E and M, M wins on a
// shared index), two combinational read ports with write-to-read bypass.
// Index 15 means "no register": never written, reads as 0, never bypassed.
module regfile_2r2w #(
    parameter int DATA_W = y86_pkg::DATA_W,
    parameter int NREG   = y86_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        wbDstE,
    input  logic [DATA_W-1:0] wbValE,
    input  logic [3:0]        wbDstM,
    input  logic [DATA_W-1:0] wbValM,
    input  logic [3:0]        rdSrcA,
    input  logic [3:0]        rdSrcB,
    output logic [DATA_W-1:0] rdValA,
    output logic [DATA_W-1:0] rdValB
);
    import y86_pkg::*;

    logic [DATA_W-1:0] regs [NREG];

    // Register storage: synchronous clear, then E write followed by M write so M wins.
    // NOTE: the whole array is cleared on reset because software may read any
    // register before writing it; this makes it a flop bank rather than a RAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking writes; when both ports hit the same index the
            // later statement (M) is the one that lands.
            if (wbDstE != REG_NONE) regs[wbDstE] <= wbValE;
            if (wbDstM != REG_NONE) regs[wbDstM] <= wbValM;
        end
    end

    // Read port A: none -> 0, else M bypass, else E bypass, else stored value.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // output unassigned and infers a latch.
        rdValA = '0;
        if (rdSrcA == REG_NONE)    rdValA = '0;
        else if (rdSrcA == wbDstM) rdValA = wbValM;
        else if (rdSrcA == wbDstE) rdValA = wbValE;
        else                       rdValA = regs[rdSrcA];
    end

    // Read port B: same priority as port A.
    always_comb begin
        rdValB = '0;
        if (rdSrcB == REG_NONE)    rdValB = '0;
        else if (rdSrcB == wbDstM) rdValB = wbValM;
        else if (rdSrcB == wbDstE) rdValB = wbValE;
        else                       rdValB = regs[rdSrcB];
    end

endmodule

// File: rtl/decode_regread.sv
// Decode-stage register read for the sequential Y86-64 core. Resolves
// srcA/srcB from icode/rA/rB, reads the register file (with writeback
// bypass) and registers the result in a one-entry valid/ready stage.
// Optional feature macro: DECODE_ILLEGAL_CHK_EN adds out_ilg, set for icode > 11.
module decode_regread #(
    parameter int DATA_W  = y86_pkg::DATA_W,
    parameter int NREG    = y86_pkg::NREG,
    parameter int RSP_IDX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [3:0]        wb_dstE,
    input  logic [DATA_W-1:0] wb_valE,
    input  logic [3:0]        wb_dstM,
    input  logic [DATA_W-1:0] wb_valM,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_srcA,
    output logic [3:0]        out_srcB,
`ifdef DECODE_ILLEGAL_CHK_EN
    output logic              out_ilg,
`endif
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB
);
    import y86_pkg::*;

    localparam logic [3:0] RSP = 4'(RSP_IDX);

    logic [3:0]        srcA;
    logic [3:0]        srcB;
    logic [DATA_W-1:0] rdValA;
    logic [DATA_W-1:0] rdValB;
    logic              accept;

    // Source decode: which architectural registers this instruction reads.
    always_comb begin
        srcA = REG_NONE;
        srcB = REG_NONE;
        case (icode_e'(icode))
            I_RRMOV:        srcA = rA;
            I_RMMOV, I_OPQ: begin srcA = rA;  srcB = rB;  end
            I_MRMOV:        srcB = rB;
            I_CALL:         srcB = RSP;
            I_RET, I_POP:   begin srcA = RSP; srcB = RSP; end
            I_PUSH:         begin srcA = rA;  srcB = RSP; end
            default:        ;
        endcase
    end

    regfile_2r2w #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .wbDstE (wb_dstE),
        .wbValE (wb_valE),
        .wbDstM (wb_dstM),
        .wbValM (wb_valM),
        .rdSrcA (srcA),
        .rdSrcB (srcB),
        .rdValA (rdValA),
        .rdValB (rdValB)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Output stage: load a snapshot on accept, drop valid on drain, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_icode <= 4'h0;
            out_srcA  <= REG_NONE;
            out_srcB  <= REG_NONE;
            valA      <= '0;
            valB      <= '0;
`ifdef DECODE_ILLEGAL_CHK_EN
            out_ilg   <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_icode <= icode;
            out_srcA  <= srcA;
            out_srcB  <= srcB;
            valA      <= rdValA;
            valB      <= rdValB;
`ifdef DECODE_ILLEGAL_CHK_EN
            out_ilg   <= (icode > I_POP);
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_regread.sv
// Self-checking bench for decode_regread: a behavioural model of the
// register file and output stage checked every cycle, plus directed
// literal expectations. Honours DECODE_ILLEGAL_CHK_EN like the design.
module tb_decode_regread;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [3:0]  wb_dstE;
    logic [63:0] wb_valE;
    logic [3:0]  wb_dstM;
    logic [63:0] wb_valM;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [3:0]  out_srcA;
    logic [3:0]  out_srcB;
    logic [63:0] valA;
    logic [63:0] valB;
`ifdef DECODE_ILLEGAL_CHK_EN
    logic        out_ilg;
`endif

    int nChecks = 0;
    int nFails  = 0;

    decode_regread dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .rA        (rA),
        .rB        (rB),
        .wb_dstE   (wb_dstE),
        .wb_valE   (wb_valE),
        .wb_dstM   (wb_dstM),
        .wb_valM   (wb_valM),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .out_srcA  (out_srcA),
        .out_srcB  (out_srcB),
`ifdef DECODE_ILLEGAL_CHK_EN
        .out_ilg   (out_ilg),
`endif
        .valA      (valA),
        .valB      (valB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] mRegs [15];
    logic        mValid;
    logic [3:0]  mIcode, mSrcA, mSrcB;
    logic [63:0] mValA, mValB;
    logic        mIlg;

    function automatic logic [3:0] srcAOf(input int ic, input logic [3:0] ra);
        if (ic inside {2, 4, 6, 10}) return ra;
        if (ic inside {9, 11})       return 4'd4;
        return 4'd15;
    endfunction

    function automatic logic [3:0] srcBOf(input int ic, input logic [3:0] rb);
        if (ic inside {4, 5, 6})      return rb;
        if (ic inside {8, 9, 10, 11}) return 4'd4;
        return 4'd15;
    endfunction

    // Reading the register contents after this edge's writes is exactly
    // what write-to-read bypass promises.
    function automatic logic [63:0] regVal(input logic [3:0] idx);
        return (idx == 4'd15) ? 64'd0 : mRegs[idx];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) mRegs[i] = 64'd0;
            mValid = 1'b0; mIcode = 4'd0; mSrcA = 4'd15; mSrcB = 4'd15;
            mValA = 64'd0; mValB = 64'd0; mIlg = 1'b0;
        end else begin
            automatic bit acc = in_valid && (!mValid || out_ready);
            if (wb_dstE != 4'd15) mRegs[wb_dstE] = wb_valE;
            if (wb_dstM != 4'd15) mRegs[wb_dstM] = wb_valM;
            if (acc) begin
                mValid = 1'b1;
                mIcode = icode;
                mSrcA  = srcAOf(int'(icode), rA);
                mSrcB  = srcBOf(int'(icode), rB);
                mValA  = regVal(mSrcA);
                mValB  = regVal(mSrcB);
                mIlg   = (int'(icode) > 11);
            end else if (out_ready) begin
                mValid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (mValid !== 1'bx) begin
            check("in_ready", in_ready, !mValid || out_ready);
            check("out_valid", out_valid, mValid);
            if (mValid) begin
                check("out_icode", out_icode, mIcode);
                check("out_srcA", out_srcA, mSrcA);
                check("out_srcB", out_srcB, mSrcB);
                check("valA", valA, mValA);
                check("valB", valB, mValB);
`ifdef DECODE_ILLEGAL_CHK_EN
                check("out_ilg", out_ilg, mIlg);
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic noWrite();
        wb_dstE = 4'd15; wb_valE = 64'd0;
        wb_dstM = 4'd15; wb_valM = 64'd0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        icode = 4'd0; rA = 4'd15; rB = 4'd15;
        noWrite();
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_icode", out_icode, 0);
        check("rst_out_srcA", out_srcA, 4'hF);
        check("rst_out_srcB", out_srcB, 4'hF);
        check("rst_valA", valA, 0);
        check("rst_valB", valB, 0);
`ifdef DECODE_ILLEGAL_CHK_EN
        check("rst_out_ilg", out_ilg, 0);
`endif
        rst_n = 1'b1;

        // OPq rA=2 rB=3 with both registers zero.
        in_valid = 1'b1; icode = 4'd6; rA = 4'd2; rB = 4'd3;
        tick();
        check("opq_valid", out_valid, 1);
        check("opq_srcA", out_srcA, 2);
        check("opq_srcB", out_srcB, 3);
        check("opq_valA", valA, 0);
        check("opq_valB", valB, 0);

        // rrmovq reading r2 while E writes r2: bypass.
        icode = 4'd2; rA = 4'd2; rB = 4'd7;
        wb_dstE = 4'd2; wb_valE = 64'h1111;
        tick(); noWrite();
        check("byp_valA", valA, 64'h1111);
        check("byp_srcB", out_srcB, 4'hF);

        // ret while E and M both write rsp: M wins.
        icode = 4'd9;
        wb_dstE = 4'd4; wb_valE = 64'hAA;
        wb_dstM = 4'd4; wb_valM = 64'hBB;
        tick(); noWrite();
        check("ret_srcA", out_srcA, 4);
        check("ret_srcB", out_srcB, 4);
        check("ret_valA", valA, 64'hBB);
        check("ret_valB", valB, 64'hBB);

        // Idle cycle with independent E/M writes.
        in_valid = 1'b0;
        wb_dstE = 4'd5; wb_valE = 64'h5E;
        wb_dstM = 4'd6; wb_valM = 64'h6F;
        tick(); noWrite();
        check("idle_valid", out_valid, 0);

        // Accept rrmovq r2 then stall three cycles; r2 rewritten mid-stall.
        in_valid = 1'b1; icode = 4'd2; rA = 4'd2; rB = 4'd15; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin wb_dstE = 4'd2; wb_valE = 64'h55; end
            tick(); noWrite();
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_valA", valA, 64'h1111);
            check("stall_srcA", out_srcA, 2);
        end

        // Release with a new request waiting: back-to-back transfer.
        in_valid = 1'b1; icode = 4'd6; rA = 4'd2; rB = 4'd5; out_ready = 1'b1;
        tick();
        check("b2b_valid", out_valid, 1);
        check("b2b_valA", valA, 64'h55);
        check("b2b_valB", valB, 64'h5E);

        // nop reads nothing.
        icode = 4'd1; rA = 4'd2; rB = 4'd5;
        tick();
        check("nop_srcA", out_srcA, 4'hF);
        check("nop_srcB", out_srcB, 4'hF);
        check("nop_valA", valA, 0);
        check("nop_valB", valB, 0);
`ifdef DECODE_ILLEGAL_CHK_EN
        check("nop_ilg", out_ilg, 0);
`endif

        // Illegal icode 13.
        icode = 4'd13;
        tick();
        check("ilg_srcA", out_srcA, 4'hF);
        check("ilg_srcB", out_srcB, 4'hF);
`ifdef DECODE_ILLEGAL_CHK_EN
        check("ilg_flag", out_ilg, 1);
`endif

        // Sweep every icode with mixed writes and backpressure (model-checked).
        for (int i = 0; i < 32; i++) begin
            icode     = 4'(i);
            rA        = 4'((i * 3) % 15);
            rB        = 4'((i * 7 + 1) % 15);
            wb_dstE   = 4'(i * 5);
            wb_valE   = 64'h1000_0000_0000_0000 + 64'(i);
            wb_dstM   = 4'(i * 11 + 3);
            wb_valM   = 64'h2000_0000_0000_0000 + 64'(i);
            in_valid  = (i % 4) != 3;
            out_ready = (i % 3) != 0;
            tick();
        end
        noWrite();

        // Reset while a result is held; the write during reset is dropped.
        in_valid = 1'b1; icode = 4'd2; rA = 4'd2; rB = 4'd15; out_ready = 1'b0;
        tick();
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        wb_dstE = 4'd3; wb_valE = 64'hDEAD;
        tick(); noWrite();
        check("mid_rst_valid", out_valid, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        icode = 4'd4; rA = 4'd2; rB = 4'd3;
        tick();
        check("post_rst_valA", valA, 0);
        check("post_rst_valB", valB, 0);
        in_valid = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
